serial_mag_comp: RTL and testbench



---
 rtl/cmp_pkg.sv | 15 +
 rtl/cmp_slice2.sv | 14 +
 rtl/serial_mag_comp.sv | 98 +++++++++
 tb/tb_serial_mag_comp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared FSM state type and one-hot {eq,gt,lt} result encodings
// for the serial magnitude comparator.
package cmp_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   localparam logic [2:0] CMP_EQ = 3'b100;
   localparam logic [2:0] CMP_GT = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

endpackage

// File: rtl/cmp_slice2.sv
// cmp_slice2: combinational comparator for one 2-bit digit pair.
module cmp_slice2 (
   input  logic [1:0] x,
   input  logic [1:0] y,
   output logic       e,
   output logic       g,
   output logic       l
);

   assign g = (x[1] & ~y[1]) | ((x[1] ~^ y[1]) & x[0] & ~y[0]);
   assign l = (~x[1] & y[1]) | ((x[1] ~^ y[1]) & ~x[0] & y[0]);
   assign e = (x == y);

endmodule

// File: rtl/serial_mag_comp.sv
// serial_mag_comp: multi-cycle unsigned magnitude comparator; walks 2-bit digit
// pairs MSB first and stops at the first unequal pair.
module serial_mag_comp
   import cmp_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             eq,
   output logic             gt,
   output logic             lt,
   output logic             busy
);

   localparam int DIGITS = WIDTH / 2;
   localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("serial_mag_comp: WIDTH must be even and >= 2");
   end

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       res_q, res_d;
   logic             pe, pg, pl;

   cmp_slice2 u_slice (
      .x(sa_q[WIDTH-1 -: 2]),
      .y(sb_q[WIDTH-1 -: 2]),
      .e(pe),
      .g(pg),
      .l(pl)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         sa_q    <= sa_d;
         sb_q    <= sb_d;
         cnt_q   <= cnt_d;
         res_q   <= res_d;
      end
   end

   // The result vector is only ever non-zero in DONE, so the one-hot
   // invariant follows from the state encoding alone.
   always_comb begin
      state_d = state_q;
      sa_d    = sa_q;
      sb_d    = sb_q;
      cnt_d   = cnt_q;
      res_d   = res_q;
      case (state_q)
         IDLE: if (in_valid) begin
            sa_d    = a;
            sb_d    = b;
            cnt_d   = CW'(DIGITS - 1);
            res_d   = '0;
            state_d = RUN;
         end
         RUN: if (pe && cnt_q != '0) begin
            sa_d  = sa_q << 2;
            sb_d  = sb_q << 2;
            cnt_d = cnt_q - CW'(1);
         end else begin
            res_d   = pe ? CMP_EQ : (pg ? CMP_GT : CMP_LT);
            state_d = DONE;
         end
         DONE: if (out_ready) begin
            res_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign in_ready  = (state_q == IDLE);
   assign busy      = (state_q != IDLE);
   assign out_valid = (state_q == DONE);
   assign eq        = res_q[2];
   assign gt        = res_q[1];
   assign lt        = res_q[0];

endmodule

// File: tb/tb_serial_mag_comp.sv
// tb_serial_mag_comp: scoreboard bench; accepted operands push an expected
// verdict and latency, a negedge monitor pops and checks each result.
module tb_serial_mag_comp;

   typedef struct {
      logic [2:0] res;
      int         lat;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, out_valid, out_ready, eq, gt, lt, busy;
   logic [7:0] a, b;

   logic       in2_valid, in2_ready, out2_valid, eq2, gt2, lt2, busy2;
   logic [1:0] a2, b2;

   exp_t exp_q[$];
   exp_t cur;
   int   n_chk = 0, n_fail = 0, cyc = 0;
   bit   ov_prev = 0, hs_prev = 0, strm = 0, have_last = 0;
   int   last_acc, last_lat;

   always #5 clk = ~clk;

   serial_mag_comp #(.WIDTH(8)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .eq(eq), .gt(gt), .lt(lt), .busy(busy)
   );

   serial_mag_comp #(.WIDTH(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in2_valid), .in_ready(in2_ready),
      .a(a2), .b(b2), .out_valid(out2_valid), .out_ready(1'b1),
      .eq(eq2), .gt(gt2), .lt(lt2), .busy(busy2)
   );

   function automatic void chk(bit ok, string nm, int act, int exp_v);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp_v);
      end
   endfunction

   function automatic logic [2:0] ref_res(logic [7:0] x, logic [7:0] y);
      return {x == y, x > y, x < y};
   endfunction

   // Edges from accept to result: first differing pair index + 1, else DIGITS.
   function automatic int ref_lat(logic [7:0] x, logic [7:0] y);
      for (int k = 0; k < 4; k++)
         if (x[7-2*k -: 2] != y[7-2*k -: 2]) return k + 1;
      return 4;
   endfunction

   initial forever @(posedge clk) cyc++;

   initial forever @(negedge rst_n) exp_q.delete();

   // Monitor and accept sampler, both on the falling edge.
   initial forever begin
      @(negedge clk);
      chk(out_valid ? $onehot({eq, gt, lt}) : ({eq, gt, lt} == 3'b000),
          "onehot", {eq, gt, lt}, out_valid);
      if (hs_prev)
         chk(!out_valid && in_ready, "release", {out_valid, in_ready}, 1);
      if (out_valid && !ov_prev) begin
         if (exp_q.size() == 0) begin
            chk(0, "unexpected_result", {eq, gt, lt}, 0);
         end else begin
            cur = exp_q.pop_front();
            chk({eq, gt, lt} == cur.res, "result", {eq, gt, lt}, cur.res);
            chk(cyc - cur.acc == cur.lat, "latency", cyc - cur.acc, cur.lat);
         end
      end else if (out_valid) begin
         chk({eq, gt, lt} == cur.res, "stable", {eq, gt, lt}, cur.res);
      end
      hs_prev = out_valid && out_ready;
      ov_prev = out_valid;
      if (rst_n && in_valid && in_ready) begin
         if (strm && have_last)
            chk(cyc + 1 - last_acc == last_lat + 2, "spacing", cyc + 1 - last_acc, last_lat + 2);
         exp_q.push_back('{res: ref_res(a, b), lat: ref_lat(a, b), acc: cyc + 1});
         have_last = 1;
         last_acc  = cyc + 1;
         last_lat  = ref_lat(a, b);
      end
   end

   task automatic send(input logic [7:0] x, input logic [7:0] y);
      bit ok = 0;
      a = x;
      b = y;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
      end
      if (!ok) chk(0, "send_timeout", 0, 1);
      @(posedge clk) #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = !busy;
      end
      if (!ok) chk(0, "idle_timeout", busy, 0);
      @(posedge clk) #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      logic [7:0] x;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
      in2_valid = 1'b0; a2 = '0; b2 = '0;
      repeat (2) begin
         @(negedge clk);
         chk(in_ready && !busy, "reset_ready", {in_ready, busy}, 2);
         chk({out_valid, eq, gt, lt} == 4'b0, "reset_out", {out_valid, eq, gt, lt}, 0);
      end
      @(posedge clk) #1;
      rst_n = 1'b1;
      @(posedge clk) #1;

      send(8'hA5, 8'hA5); wait_idle();
      send(8'hC0, 8'h40); wait_idle();
      send(8'h12, 8'h13); wait_idle();

      // Consumer stalls; a new operand pulse while busy must be ignored.
      out_ready = 1'b0;
      send(8'h80, 8'h7F);
      ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      chk(ok, "hold_wait", ok, 1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk) #1;
         in_valid = (i == 2);
         a = 8'h00; b = 8'hFF;
         @(negedge clk);
         chk(out_valid && gt && !in_ready && busy, "hold",
             {out_valid, gt, in_ready, busy}, 4'b1101);
      end
      @(posedge clk) #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      wait_idle();

      // Abort during the second RUN cycle.
      send(8'h01, 8'h02);
      @(posedge clk) #1;
      rst_n = 1'b0;
      #1;
      chk(in_ready && !busy && !out_valid, "abort", {in_ready, busy, out_valid}, 4);
      @(posedge clk) #1;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      send(8'hFF, 8'h00); wait_idle();

      // Back-to-back stream with in_valid and out_ready held high.
      strm = 1; have_last = 0;
      in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         x = 8'($urandom);
         a = x;
         b = x ^ (8'($urandom) >> (2 * $urandom_range(0, 4)));
         ok = 0;
         for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
         end
         if (!ok) chk(0, "stream_timeout", 0, 1);
         @(posedge clk) #1;
      end
      in_valid = 1'b0;
      strm = 0;
      wait_idle();
      repeat (3) @(posedge clk);
      chk(exp_q.size() == 0, "drained", exp_q.size(), 0);

      // WIDTH=2 instance: every operand pair, single RUN cycle.
      for (int v = 0; v < 16; v++) begin
         @(posedge clk) #1;
         a2 = 2'(v >> 2); b2 = 2'(v);
         in2_valid = 1'b1;
         @(negedge clk);
         chk(in2_ready, "w2_ready", in2_ready, 1);
         @(posedge clk) #1;
         in2_valid = 1'b0;
         @(negedge clk);
         chk(!out2_valid && busy2, "w2_run", {out2_valid, busy2}, 1);
         @(negedge clk);
         chk(out2_valid, "w2_valid", out2_valid, 1);
         chk({eq2, gt2, lt2} == {a2 == b2, a2 > b2, a2 < b2}, "w2_result",
             {eq2, gt2, lt2}, {a2 == b2, a2 > b2, a2 < b2});
         @(posedge clk);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
